vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA/raster timing generator: successor to the fixed 640x480 sync generator.
- Derives the pixel rate as a clock-enable from the system clock; no generated clocks.
- Drives programmable h/v counters, sync pulses with selectable polarity, data-enable, and line/frame strobes consumed by pixel-pattern and framebuffer readers downstream.

Parameters:
- CLK_DIV, 2: system clocks per pixel (>=1; 1 = pixel every clock).
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, pixels.
- H_SYNC, 96: hsync width, pixels.
- H_BP, 48: horizontal back porch, pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, lines.
- V_SYNC, 2: vsync width, lines.
- V_BP, 33: vertical back porch, lines.
- H_POL, 0: hsync active level.
- V_POL, 0: vsync active level.
- X_W, 11: width of x counter/output.
- Y_W, 10: width of y counter/output.

Ports:
- clk, input, 1: system clock.
- Reset, input, 1: synchronous, active-high reset.
- en, input, 1: run enable; low freezes timing.
- pix_stb, output, 1: one-clk strobe; outputs describe a new pixel this cycle.
- hsync, output, 1: horizontal sync at H_POL when active.
- vsync, output, 1: vertical sync at V_POL when active.
- de, output, 1: display enable (visible region).
- x, output, X_W: current horizontal count, 0..H_TOTAL-1.
- y, output, Y_W: current vertical count, 0..V_TOTAL-1.
- line_start, output, 1: one-clk strobe with pix_stb when x==0.
- frame_start, output, 1: one-clk strobe with pix_stb when x==0 and y==0.

Behaviour:
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Parameter check: H_TOTAL>2^X_W, V_TOTAL>2^Y_W, or CLK_DIV<1 → simulation $error at elaboration.
- Divider: counter 0..CLK_DIV-1 advancing each clk while en=1. Internal ce is high in the clk where the divider equals CLK_DIV-1; divider then wraps to 0. CLK_DIV=1 → ce every clk with en=1.
- Counters and outputs all update on the clk edge ending a ce cycle.
- h: H_TOTAL-1 wraps to 0, else +1.
- v: +1 only when h wraps; V_TOTAL-1 wraps to 0.
- All outputs are registered and describe the new (h,v) position, so x, y, de, hsync and vsync are mutually aligned. They hold between strobes.
- pix_stb, line_start and frame_start are high only in the single clk following the update edge.
- de = (h<H_ACTIVE) && (v<V_ACTIVE).
- hsync = H_POL while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; else ~H_POL.
- vsync = V_POL while V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; else ~V_POL. vsync transitions only with h==0.
- Reset state:
  - Internal h=H_TOTAL-1, v=V_TOTAL-1, divider=0.
  - Outputs: x=0, y=0, de=0, hsync=~H_POL, vsync=~V_POL, pix_stb=0, line_start=0, frame_start=0.
  - The first ce after reset therefore lands on (0,0) with frame_start.
- Reset dominates en and ce. Reset asserted mid-frame for one clk restores reset state on the next edge, with no partial strobes.
- en=0: divider, counters and outputs hold; strobes forced 0. Resume continues the divider from its held value, with no skipped or repeated pixel.
- Vertical advance and horizontal wrap in the same edge are the normal case. At (H_TOTAL-1,V_TOTAL-1) the next pixel is (0,0) with line_start=frame_start=1.

Decomposition:
- Shared package vga_timing_pkg:
  - Default 640x480@60 constants (H_ACTIVE..V_BP, polarities).
  - 800x600@60 constant set.
  - Function computing total from the four segment values.
- One sub-module: pix_ce_gen (parameter CLK_DIV; ports clk, Reset, en, ce).
- Counters and decode stay in vga_timing_gen.

Test Plan:
1. Defaults, deassert Reset → first pix_stb 2 clks later with x=0, y=0, de=1, hsync=1, vsync=1, line_start=1, frame_start=1; pix_stb every 2nd clk thereafter.
2. Run one line → de low for x=640..799; hsync=0 for exactly x=656..751 (96 strobes); line_start period 800 strobes (1600 clk).
3. Run one frame → vsync=0 for y=490..491 (1600 strobes), first low at x=0,y=490; frame_start period 420000 strobes (840000 clk); de high count 307200.
4. At x=799, y=524 → next strobe x=0, y=0, frame_start=1, de=1; no strobe with x=800 or y=525.
5. en low at x=100 for 37 clks → no strobes, all outputs hold; after en high, next strobe x=101, same y.
6. Reset for 1 clk at x=300, y=200 → next clk outputs at reset values. With CLK_DIV=1, H_POL=V_POL=1 and H 8/2/3/2, V 4/1/1/1: hsync=1 only at x=10..12; strobe every clk.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the VGA timing generator.
package vga_timing_pkg;

    // 640x480@60 (25.175 MHz nominal pixel clock), negative sync polarities
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_H_POL    = 1'b0;
    localparam bit DEF_V_POL    = 1'b0;

    // 800x600@60 (40 MHz pixel clock), positive sync polarities
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;
    localparam bit SVGA_H_POL    = 1'b1;
    localparam bit SVGA_V_POL    = 1'b1;

    function automatic int seg_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: generator drives it, pixel/framebuffer readers consume it.
interface vga_timing_gen_if #(
    parameter int X_W = 11,
    parameter int Y_W = 10
);
    logic           pix_stb;
    logic           hsync;
    logic           vsync;
    logic           de;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           line_start;
    logic           frame_start;

    modport master (output pix_stb, hsync, vsync, de, x, y, line_start, frame_start);
    modport slave  (input  pix_stb, hsync, vsync, de, x, y, line_start, frame_start);
endinterface

// File: rtl/pix_ce_gen.sv
// Pixel clock-enable: one ce every CLK_DIV system clocks while en is high.
module pix_ce_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic Reset,
    input  logic en,
    output logic ce
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div;

    assign ce = en && (int'(div) == CLK_DIV - 1);

    // With CLK_DIV=1 ce is high whenever en is, so div never leaves 0.
    always_ff @(posedge clk) begin
        if (Reset)
            div <= '0;
        else if (en)
            div <= ce ? '0 : div + DW'(1);
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters, sync/de decode, line/frame strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = DEF_H_POL,
    parameter bit V_POL    = DEF_V_POL,
    parameter int X_W      = 11,
    parameter int Y_W      = 10
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              en,
    vga_timing_gen_if.master  vid
);
    localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;

    if (H_TOTAL > 2**X_W || V_TOTAL > 2**Y_W || CLK_DIV < 1) begin : g_bad_params
        $error("vga_timing_gen: totals exceed counter widths or CLK_DIV < 1");
    end

    logic           ce;
    logic [X_W-1:0] h, h_nxt;
    logic [Y_W-1:0] v, v_nxt;
    int             hn, vn;

    pix_ce_gen #(.CLK_DIV(CLK_DIV)) u_ce (
        .clk   (clk),
        .Reset (Reset),
        .en    (en),
        .ce    (ce)
    );

    always_comb begin
        h_nxt = (int'(h) == H_TOTAL - 1) ? '0 : h + X_W'(1);
        v_nxt = v;
        if (int'(h) == H_TOTAL - 1)
            v_nxt = (int'(v) == V_TOTAL - 1) ? '0 : v + Y_W'(1);
        hn = int'(h_nxt);
        vn = int'(v_nxt);
    end

    // Counters start on the last pixel so the first ce lands on (0,0) with frame_start.
    always_ff @(posedge clk) begin
        if (Reset) begin
            h               <= X_W'(H_TOTAL - 1);
            v               <= Y_W'(V_TOTAL - 1);
            vid.x           <= '0;
            vid.y           <= '0;
            vid.de          <= 1'b0;
            vid.hsync       <= ~H_POL;
            vid.vsync       <= ~V_POL;
            vid.pix_stb     <= 1'b0;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
        end else begin
            vid.pix_stb     <= ce;
            vid.line_start  <= ce && (hn == 0);
            vid.frame_start <= ce && (hn == 0) && (vn == 0);
            if (ce) begin
                h         <= h_nxt;
                v         <= v_nxt;
                vid.x     <= h_nxt;
                vid.y     <= v_nxt;
                vid.de    <= (hn < H_ACTIVE) && (vn < V_ACTIVE);
                vid.hsync <= (hn >= HS_BEG && hn < HS_END) ? H_POL : ~H_POL;
                vid.vsync <= (vn >= VS_BEG && vn < VS_END) ? V_POL : ~V_POL;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing plus a tiny 15x7 raster for frame-level checks.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_a = 1'b1, en_a = 1'b1;
    logic rst_b = 1'b1, en_b = 1'b1;
    int   errors = 0, checks = 0;
    int   n, nstb, ex, ey, bad, nde_lo, de_first, nhs_lo, hs_first, hs_last, nvs_lo;
    int   nh, nv, nd, nfs, nostb, nmoved;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.X_W(11), .Y_W(10)) ia ();
    vga_timing_gen_if #(.X_W(4),  .Y_W(3))  ib ();

    vga_timing_gen dut_a (.clk(clk), .Reset(rst_a), .en(en_a), .vid(ia));

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .X_W(4), .Y_W(3)
    ) dut_b (.clk(clk), .Reset(rst_b), .en(en_b), .vid(ib));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_a_stb(input int lim, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!ia.pix_stb && cnt < lim);
    endtask

    initial begin
        tick();
        tick();
        // Reset state, both instances
        chk("a_rst_x", ia.x, 0);            chk("a_rst_y", ia.y, 0);
        chk("a_rst_de", ia.de, 0);          chk("a_rst_hs", ia.hsync, 1);
        chk("a_rst_vs", ia.vsync, 1);       chk("a_rst_stb", ia.pix_stb, 0);
        chk("a_rst_ls", ia.line_start, 0);  chk("a_rst_fs", ia.frame_start, 0);
        chk("b_rst_hs", ib.hsync, 0);       chk("b_rst_vs", ib.vsync, 0);

        // First pixel two clocks after reset release
        rst_a = 1'b0;
        tick();
        chk("a_no_stb_1clk", ia.pix_stb, 0);
        tick();
        chk("a_first_stb", ia.pix_stb, 1);  chk("a_first_x", ia.x, 0);
        chk("a_first_y", ia.y, 0);          chk("a_first_de", ia.de, 1);
        chk("a_first_hs", ia.hsync, 1);     chk("a_first_vs", ia.vsync, 1);
        chk("a_first_ls", ia.line_start, 1); chk("a_first_fs", ia.frame_start, 1);

        // One full line
        n = 0; nstb = 0; ex = 0; bad = 0; nde_lo = 0; de_first = -1;
        nhs_lo = 0; hs_first = -1; hs_last = -1; nvs_lo = 0;
        do begin
            tick();
            n++;
            if (ia.pix_stb) begin
                nstb++;
                ex = (ex == 799) ? 0 : ex + 1;
                if (int'(ia.x) != ex) bad++;
                if (!ia.de) begin
                    nde_lo++;
                    if (de_first < 0) de_first = int'(ia.x);
                end
                if (!ia.hsync) begin
                    nhs_lo++;
                    if (hs_first < 0) hs_first = int'(ia.x);
                    hs_last = int'(ia.x);
                end
                if (!ia.vsync) nvs_lo++;
            end
        end while (!(ia.pix_stb && ia.line_start) && n < 2000);
        chk("a_line_clks", n, 1600);        chk("a_line_stbs", nstb, 800);
        chk("a_line_xseq", bad, 0);         chk("a_de_lo_cnt", nde_lo, 160);
        chk("a_de_lo_first", de_first, 640); chk("a_hs_lo_cnt", nhs_lo, 96);
        chk("a_hs_first", hs_first, 656);   chk("a_hs_last", hs_last, 751);
        chk("a_vs_lo_cnt", nvs_lo, 0);
        chk("a_line2_y", ia.y, 1);          chk("a_line2_fs", ia.frame_start, 0);

        // Freeze with en low at x=100
        n = 0;
        while (!(ia.pix_stb && ia.x == 11'd100) && n < 1000) begin
            tick();
            n++;
        end
        chk("a_reach_x100", ia.x, 100);
        en_a = 1'b0;
        nstb = 0; nmoved = 0;
        for (int i = 0; i < 37; i++) begin
            tick();
            if (ia.pix_stb) nstb++;
            if (ia.x != 11'd100 || ia.y != 10'd1 || !ia.de || !ia.hsync) nmoved++;
        end
        chk("a_frz_stbs", nstb, 0);         chk("a_frz_hold", nmoved, 0);
        en_a = 1'b1;
        wait_a_stb(10, n);
        chk("a_resume_clks", n, 2);         chk("a_resume_x", ia.x, 101);
        chk("a_resume_y", ia.y, 1);

        // One-clock reset mid-line
        n = 0;
        while (!(ia.pix_stb && ia.x == 11'd300) && n < 1000) begin
            tick();
            n++;
        end
        chk("a_reach_x300", ia.x, 300);
        rst_a = 1'b1;
        tick();
        chk("a_mrst_x", ia.x, 0);           chk("a_mrst_y", ia.y, 0);
        chk("a_mrst_de", ia.de, 0);         chk("a_mrst_stb", ia.pix_stb, 0);
        chk("a_mrst_ls", ia.line_start, 0); chk("a_mrst_fs", ia.frame_start, 0);
        rst_a = 1'b0;
        wait_a_stb(10, n);
        chk("a_mrst_relat", n, 2);          chk("a_mrst_fs2", ia.frame_start, 1);
        rst_a = 1'b1;

        // Tiny raster: strobe every clock, full frame and wrap
        rst_b = 1'b0;
        tick();
        chk("b_first_stb", ib.pix_stb, 1);  chk("b_first_fs", ib.frame_start, 1);
        chk("b_first_x", ib.x, 0);          chk("b_first_hs", ib.hsync, 0);
        ex = 0; ey = 0; bad = 0; nh = 0; nv = 0; nd = 0; nfs = 0; nostb = 0;
        for (int i = 0; i < 104; i++) begin
            tick();
            ex = (ex == 14) ? 0 : ex + 1;
            if (ex == 0) ey = (ey == 6) ? 0 : ey + 1;
            if (!ib.pix_stb) nostb++;
            if (int'(ib.x) != ex || int'(ib.y) != ey) bad++;
            if (ib.hsync !== (ex >= 10 && ex <= 12)) bad++;
            if (ib.vsync !== (ey == 5)) bad++;
            if (ib.hsync) nh++;
            if (ib.vsync) nv++;
            if (ib.de) nd++;
            if (ib.frame_start) nfs++;
        end
        chk("b_nostb", nostb, 0);           chk("b_pos_sync_seq", bad, 0);
        chk("b_hs_cnt", nh, 21);            chk("b_vs_cnt", nv, 15);
        chk("b_de_cnt", nd, 31);            chk("b_fs_cnt", nfs, 0);
        chk("b_last_x", ib.x, 14);          chk("b_last_y", ib.y, 6);
        tick();
        chk("b_wrap_x", ib.x, 0);           chk("b_wrap_y", ib.y, 0);
        chk("b_wrap_fs", ib.frame_start, 1); chk("b_wrap_ls", ib.line_start, 1);
        chk("b_wrap_de", ib.de, 1);

        // Mid-frame reset on the tiny raster
        for (int i = 0; i < 33; i++) tick();
        chk("b_at_x", ib.x, 3);             chk("b_at_y", ib.y, 2);
        rst_b = 1'b1;
        tick();
        chk("b_mrst_x", ib.x, 0);           chk("b_mrst_y", ib.y, 0);
        chk("b_mrst_stb", ib.pix_stb, 0);   chk("b_mrst_vs", ib.vsync, 0);
        rst_b = 1'b0;
        tick();
        chk("b_mrst_fs", ib.frame_start, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
